// File: rtl/scope_pkg.sv
// scope_pkg: shared default sizes and the capture FSM state type for the
// per-channel scope capture path.
package scope_pkg;

  localparam int unsigned DEFAULT_DATA_W = 12;
  localparam int unsigned DEFAULT_DEPTH  = 640;
  localparam int unsigned DEFAULT_ADDR_W = 10;

  typedef enum logic [2:0] {
    CAP_IDLE,
    CAP_PREFILL,
    CAP_ARMED,
    CAP_POST,
    CAP_DONE
  } cap_state_e;

endpackage

// File: rtl/capture_ram.sv
// capture_ram: 2*DEPTH-word simple dual-port RAM, one write port and one
// registered read port, both addressed as (bank, offset) on a single clock.
module capture_ram #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned DEPTH  = 640,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clock,
  input  logic              we,
  input  logic              wr_bank,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_bank,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam logic [ADDR_W:0] BANK_OFS = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [2*DEPTH];
  logic [ADDR_W:0]   wr_idx;
  logic [ADDR_W:0]   rd_idx;
  logic [DATA_W-1:0] rd_data_q;

  always_comb begin
    wr_idx = {1'b0, wr_addr} + (wr_bank ? BANK_OFS : '0);
    rd_idx = {1'b0, rd_addr} + (rd_bank ? BANK_OFS : '0);
  end

  always_ff @(posedge clock) begin
    if (we) begin
      mem[wr_idx] <= wr_data;
    end
    rd_data_q <= mem[rd_idx];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/trigger_capture.sv
// trigger_capture: threshold-triggered, double-buffered frame capture for one
// scope channel. Define TRIG_AUTO_EN to force a trigger after AUTO_TIMEOUT armed samples.
module trigger_capture
  import scope_pkg::*;
#(
  parameter int unsigned DATA_W       = DEFAULT_DATA_W,
  parameter int unsigned DEPTH        = DEFAULT_DEPTH,
  parameter int unsigned ADDR_W       = DEFAULT_ADDR_W,
  parameter int unsigned PRETRIG      = 160,
  parameter int unsigned AUTO_TIMEOUT = 4096
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              sample_en,
  input  logic [DATA_W-1:0] data,
  input  logic [DATA_W-1:0] threshold,
  input  logic              edge_sel,
  input  logic              hold,
  input  logic [10:0]       screenX,
  output logic [DATA_W-1:0] screenData,
  output logic              frame_valid,
  output logic              triggered,
  output logic              resample
);

  if (PRETRIG < 1 || PRETRIG >= DEPTH) begin : g_bad_pretrig
    $error("trigger_capture: PRETRIG must satisfy 1 <= PRETRIG < DEPTH");
  end
  if ((2 ** ADDR_W) < DEPTH) begin : g_bad_addr_w
    $error("trigger_capture: ADDR_W too narrow for DEPTH");
  end
  if (AUTO_TIMEOUT < 1) begin : g_bad_timeout
    $error("trigger_capture: AUTO_TIMEOUT must be at least 1");
  end

  localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   BACK_OFS = (ADDR_W+1)'(DEPTH - PRETRIG);
  localparam logic [ADDR_W:0]   ONE_X    = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST_PRE = ADDR_W'(PRETRIG - 1);
  localparam logic [ADDR_W-1:0] POST_LEN = ADDR_W'(DEPTH - PRETRIG - 1);

  cap_state_e        state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] start_ptr_q, start_ptr_d;
  logic [ADDR_W-1:0] disp_start_q, disp_start_d;
  logic [ADDR_W-1:0] post_cnt_q, post_cnt_d;
  logic [DATA_W-1:0] prev_q, prev_d;
  logic              bank_sel_q, bank_sel_d;
  logic              frame_valid_q, frame_valid_d;
  logic              resample_q, resample_d;
  logic              rd_zero_q, rd_zero_d;

  logic              ram_we;
  logic [ADDR_W-1:0] ptr_inc;
  logic [ADDR_W-1:0] start_calc;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] ram_rdata;
  logic              in_range;
  logic              rise_hit, fall_hit, edge_hit, trig_hit;
  logic              auto_hit;

  // Reduce a value below 2*DEPTH into 0..DEPTH-1 by one conditional subtract.
  function automatic logic [ADDR_W-1:0] wrap(input logic [ADDR_W:0] v);
    logic [ADDR_W:0] r;
    r = (v >= DEPTH_X) ? v - DEPTH_X : v;
    return r[ADDR_W-1:0];
  endfunction

`ifdef TRIG_AUTO_EN
  localparam int unsigned      ARM_W    = $clog2(AUTO_TIMEOUT + 1);
  localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(AUTO_TIMEOUT - 1);
  localparam logic [ARM_W-1:0] ARM_ONE  = ARM_W'(1);

  logic [ARM_W-1:0] arm_cnt_q, arm_cnt_d;

  always_comb begin
    auto_hit = (arm_cnt_q == ARM_LAST);
  end
`else
  always_comb begin
    auto_hit = 1'b0;
  end
`endif

  always_comb begin
    ptr_inc    = wrap({1'b0, wr_ptr_q} + ONE_X);
    start_calc = wrap({1'b0, wr_ptr_q} + BACK_OFS);
    rd_addr    = wrap({1'b0, disp_start_q} + (ADDR_W+1)'(screenX));
    in_range   = (32'(screenX) < DEPTH);
    rise_hit   = (prev_q < threshold) && (data >= threshold);
    fall_hit   = (prev_q >= threshold) && (data < threshold);
    edge_hit   = edge_sel ? fall_hit : rise_hit;
    trig_hit   = edge_hit || auto_hit;
  end

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    start_ptr_d   = start_ptr_q;
    disp_start_d  = disp_start_q;
    post_cnt_d    = post_cnt_q;
    prev_d        = prev_q;
    bank_sel_d    = bank_sel_q;
    frame_valid_d = frame_valid_q;
    resample_d    = 1'b0;
    ram_we        = 1'b0;
    rd_zero_d     = !(in_range && frame_valid_q);
`ifdef TRIG_AUTO_EN
    arm_cnt_d     = arm_cnt_q;
`endif
    case (state_q)
      CAP_IDLE: begin
        wr_ptr_d = '0;
        state_d  = CAP_PREFILL;
      end
      CAP_PREFILL: begin
        if (sample_en) begin
          ram_we   = 1'b1;
          wr_ptr_d = ptr_inc;
          prev_d   = data;
          // wr_ptr starts at 0 on every PREFILL entry, so it doubles as the prefill count
          if (wr_ptr_q == LAST_PRE) begin
            state_d = CAP_ARMED;
`ifdef TRIG_AUTO_EN
            arm_cnt_d = '0;
`endif
          end
        end
      end
      CAP_ARMED: begin
        if (sample_en) begin
          ram_we   = 1'b1;
          wr_ptr_d = ptr_inc;
          prev_d   = data;
`ifdef TRIG_AUTO_EN
          arm_cnt_d = arm_cnt_q + ARM_ONE;
`endif
          if (trig_hit) begin
            start_ptr_d = start_calc;
            post_cnt_d  = POST_LEN;
            state_d     = CAP_POST;
          end
        end
      end
      CAP_POST: begin
        if (sample_en) begin
          ram_we   = 1'b1;
          wr_ptr_d = ptr_inc;
          prev_d   = data;
          // post_cnt holds the POST strobes still owed, this one included
          if (post_cnt_q <= ONE_A) begin
            state_d = CAP_DONE;
          end else begin
            post_cnt_d = post_cnt_q - ONE_A;
          end
        end
      end
      CAP_DONE: begin
        if (!hold) begin
          bank_sel_d    = !bank_sel_q;
          disp_start_d  = start_ptr_q;
          frame_valid_d = 1'b1;
          resample_d    = 1'b1;
          wr_ptr_d      = '0;
          state_d       = CAP_PREFILL;
        end
      end
      default: begin
        state_d = CAP_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= CAP_IDLE;
      wr_ptr_q      <= '0;
      start_ptr_q   <= '0;
      disp_start_q  <= '0;
      post_cnt_q    <= '0;
      prev_q        <= '0;
      bank_sel_q    <= 1'b0;
      frame_valid_q <= 1'b0;
      resample_q    <= 1'b0;
      rd_zero_q     <= 1'b1;
`ifdef TRIG_AUTO_EN
      arm_cnt_q     <= '0;
`endif
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      start_ptr_q   <= start_ptr_d;
      disp_start_q  <= disp_start_d;
      post_cnt_q    <= post_cnt_d;
      prev_q        <= prev_d;
      bank_sel_q    <= bank_sel_d;
      frame_valid_q <= frame_valid_d;
      resample_q    <= resample_d;
      rd_zero_q     <= rd_zero_d;
`ifdef TRIG_AUTO_EN
      arm_cnt_q     <= arm_cnt_d;
`endif
    end
  end

  capture_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clock   (clock),
    .we      (ram_we),
    .wr_bank (bank_sel_q),
    .wr_addr (wr_ptr_q),
    .wr_data (data),
    .rd_bank (!bank_sel_q),
    .rd_addr (rd_addr),
    .rd_data (ram_rdata)
  );

  assign screenData  = rd_zero_q ? '0 : ram_rdata;
  assign frame_valid = frame_valid_q;
  assign resample    = resample_q;
  assign triggered   = (state_q == CAP_POST) || (state_q == CAP_DONE);

endmodule
